// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg: snapshot FSM states and default sizing shared with the display side
package frame_sync_pkg;
  typedef enum logic [1:0] {S_IDLE, S_COPY, S_COMMIT} snap_state_t;
  localparam int NUM_ENTRIES_DEF   = 51;
  localparam int IDX_W_DEF         = 6;
  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int CNT_W_DEF         = 16;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer plus a third flop for a one-cycle rise pulse
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);
  logic [2:0] sh_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else sh_q <= {sh_q[1:0], d_i};
  assign rise_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/frame_snapshot_ctrl.sv
// frame_snapshot_ctrl: copies game state into a shadow bank during vblank, then commits it atomically
module frame_snapshot_ctrl
  import frame_sync_pkg::*;
#(
  parameter int NUM_ENTRIES   = NUM_ENTRIES_DEF,
  parameter int IDX_W         = IDX_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             vs,
  input  logic             game_tick,
  output logic [IDX_W-1:0] copy_idx,
  output logic             copy_we,
  output logic             commit,
  output logic             busy,
  output logic [CNT_W-1:0] commit_cnt,
  output logic [7:0]       skip_cnt,
  output logic [7:0]       abort_cnt
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  snap_state_t state_q;
  logic tick_rise, vs_q, vs_fall, pending_q, settled_q, we_q, abort;
  logic [SW-1:0] settle_q;
  sync_edge_det u_tick (.clk(clk), .rst_n(rst_n), .d_i(game_tick), .rise_o(tick_rise));
  assign vs_fall = vs_q & ~vs;
  assign abort   = (state_q == S_COPY) & (tick_rise | ~enable);
  // the aborting cycle's source data may already be mid-update, so its write is suppressed
  assign copy_we = we_q & ~abort;
  assign busy    = state_q != S_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_q      <= 1'b0;
      pending_q <= 1'b0;
      settled_q <= 1'b0;
      settle_q  <= '0;
    end else begin
      vs_q <= vs;
      if (tick_rise) begin
        pending_q <= 1'b1;
        settled_q <= 1'b0;
        settle_q  <= '0;
      end else begin
        if (state_q == S_COMMIT) pending_q <= 1'b0;
        if (!settled_q) begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) settled_q <= 1'b1;
          else settle_q <= settle_q + SW'(1);
        end
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      copy_idx   <= '0;
      commit     <= 1'b0;
      commit_cnt <= '0;
      skip_cnt   <= '0;
      abort_cnt  <= '0;
    end else begin
      case (state_q)
        S_IDLE:
          if (vs_fall) begin
            if (enable & pending_q & settled_q & ~tick_rise) begin
              state_q  <= S_COPY;
              we_q     <= 1'b1;
              copy_idx <= '0;
            end else skip_cnt <= skip_cnt + 8'(skip_cnt != 8'hff);
          end
        S_COPY:
          if (abort) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            copy_idx  <= '0;
            abort_cnt <= abort_cnt + 8'(abort_cnt != 8'hff);
          end else if (copy_idx == IDX_W'(NUM_ENTRIES - 1)) begin
            state_q  <= S_COMMIT;
            we_q     <= 1'b0;
            copy_idx <= '0;
            commit   <= 1'b1;
          end else copy_idx <= copy_idx + IDX_W'(1);
        S_COMMIT: begin
          state_q    <= S_IDLE;
          commit     <= 1'b0;
          commit_cnt <= commit_cnt + CNT_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_frame_snapshot_ctrl.sv
// tb_frame_snapshot_ctrl: directed vectors for copy/commit sequencing, skips, aborts and reset
module tb_frame_snapshot_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, vs = 1'b1, game_tick = 1'b0;
  logic [5:0] copy_idx;
  logic copy_we, commit, busy;
  logic [15:0] commit_cnt;
  logic [7:0] skip_cnt, abort_cnt;
  int n_checks = 0, n_err = 0;

  frame_snapshot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vs(vs), .game_tick(game_tick),
    .copy_idx(copy_idx), .copy_we(copy_we), .commit(commit), .busy(busy),
    .commit_cnt(commit_cnt), .skip_cnt(skip_cnt), .abort_cnt(abort_cnt)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    game_tick = 1'b1;
    repeat (3) @(negedge clk);
    game_tick = 1'b0;
  endtask

  task automatic vs_fall_start();
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic vs_end(input int n);
    repeat (n) @(negedge clk);
    vs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic full_copy(input string tag, input logic [31:0] exp_cnt);
    int bad = 0;
    for (int i = 0; i < 51; i++) begin
      if (copy_we !== 1'b1 || copy_idx !== 6'(i) || commit !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk({tag, "_run"}, bad, 0);
    chk({tag, "_commit"}, commit, 1);
    chk({tag, "_we_off"}, copy_we, 0);
    @(negedge clk);
    chk({tag, "_pulse1"}, commit, 0);
    chk({tag, "_cnt"}, commit_cnt, exp_cnt);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", {copy_we, commit, busy, copy_idx}, 0);
    chk("rst_cnts", {commit_cnt, skip_cnt, abort_cnt}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // 1: settled tick then vblank gives a full copy and one commit
    tick();
    repeat (20) @(negedge clk);
    vs_fall_start();
    full_copy("t1", 1);
    chk("t1_skip", skip_cnt, 0);
    vs_end(2);
    // 2: no new tick means a skip
    vs_fall_start();
    chk("t2_no_we", copy_we, 0);
    chk("t2_no_busy", busy, 0);
    vs_end(2);
    chk("t2_skip", skip_cnt, 1);
    chk("t2_commits", commit_cnt, 1);
    // 3: unsettled tick skips, next vblank copies
    tick();
    vs_fall_start();
    chk("t3_no_we", copy_we, 0);
    vs_end(20);
    chk("t3_skip", skip_cnt, 2);
    vs_fall_start();
    full_copy("t3", 2);
    vs_end(2);
    // 4: tick rise while copying idx 20 aborts
    tick();
    repeat (20) @(negedge clk);
    vs_fall_start();
    repeat (18) @(negedge clk);
    chk("t4_idx18", copy_idx, 18);
    game_tick = 1'b1;
    @(negedge clk);
    chk("t4_we19", copy_we, 1);
    @(negedge clk);
    chk("t4_idx20", copy_idx, 20);
    chk("t4_we_gated", copy_we, 0);
    @(negedge clk);
    chk("t4_idle", busy, 0);
    chk("t4_abort", abort_cnt, 1);
    chk("t4_idx0", copy_idx, 0);
    chk("t4_no_commit", commit, 0);
    game_tick = 1'b0;
    vs_end(5);
    chk("t4_commits", commit_cnt, 2);
    repeat (15) @(negedge clk);
    vs_fall_start();
    full_copy("t4b", 3);
    vs_end(2);
    // 5: enable drop at idx 10 aborts, disabled vblanks skip, re-enable commits
    tick();
    repeat (20) @(negedge clk);
    vs_fall_start();
    repeat (10) @(negedge clk);
    chk("t5_idx10", copy_idx, 10);
    enable = 1'b0;
    #1;
    chk("t5_we_gated", copy_we, 0);
    @(negedge clk);
    chk("t5_idle", busy, 0);
    chk("t5_abort", abort_cnt, 2);
    vs_end(2);
    repeat (2) begin
      vs_fall_start();
      chk("t5_dis_we", copy_we, 0);
      vs_end(2);
    end
    chk("t5_skip", skip_cnt, 4);
    enable = 1'b1;
    vs_fall_start();
    full_copy("t5b", 4);
    vs_end(2);
    // 6: async reset mid-copy, then skip_cnt saturation
    tick();
    repeat (20) @(negedge clk);
    vs_fall_start();
    repeat (30) @(negedge clk);
    chk("t6_idx30", copy_idx, 30);
    #5 rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {copy_we, commit, busy, copy_idx}, 0);
    chk("t6_rst_cnts", {commit_cnt, skip_cnt, abort_cnt}, 0);
    vs = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    repeat (254) begin
      @(negedge clk) vs = 1'b0;
      @(negedge clk) vs = 1'b1;
    end
    @(negedge clk);
    chk("t6_skip254", skip_cnt, 254);
    repeat (46) begin
      @(negedge clk) vs = 1'b0;
      @(negedge clk) vs = 1'b1;
    end
    @(negedge clk);
    chk("t6_skip_sat", skip_cnt, 255);
    chk("t6_commits", commit_cnt, 0);
    chk("t6_aborts", abort_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
